// File: rtl/tt_um_uart_tx.sv
// UART transmitter (8 data bits, 1 stop bit) with a registered tx line and a valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module tt_um_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_START  = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
  localparam logic [ST_W-1:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [ST_W-1:0] ST_PARITY = 3'd4;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             tx_valid;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic unused_c;
  assign unused_c = ^{ena, uio_in[7:1]};

  assign tx_valid = uio_in[0];
  assign bit_end  = (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic; the tx line is precomputed from the next state so it is registered
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d  = ST_START;
          shreg_d  = ui_in;
          cnt_d    = '0;
          idx_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^ui_in;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(7)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shreg_d = shreg_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    ready_d = (state_d == ST_IDLE);
    done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
  end

  assign uo_out  = {4'b0000, done_q, ready_q, ~ready_q, tx_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// Scoreboard bench for tt_um_uart_tx: two instances (4 and 2 clocks per bit) with independent stimulus and monitors.
`timescale 1ns/1ps
module tb_tt_um_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       b2b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Frame bit k as defined by the UART format: start, 8 data LSB first, optional even parity, stop
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && NB == 11) return ^d;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_u
    localparam int C = (g == 0) ? 4 : 2;
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic [6:0] junk;
    logic [7:0] uo, uio_o, uio_e;
    bit         mon_en = 1'b1;
    bit         fin = 1'b0;
    exp_t       q[$];

    tt_um_uart_tx #(.CLKS_PER_BIT(C)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (1'b1),
      .ui_in  (data),
      .uio_in ({junk, valid}),
      .uo_out (uo),
      .uio_out(uio_o),
      .uio_oe (uio_e)
    );

    task automatic wait_idle();
      int t;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!uo[2] && t < 2000);
      if (!uo[2]) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic rnd, input logic [7:0] alt);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      data  = d;
      valid = 1'b1;
      junk  = 7'($urandom);
      q.push_back('{data: d, b2b: 1'b0});
      @(negedge clk);
      for (int i = 0; i < NB*C-2; i++) begin
        data  = rnd ? 8'($urandom) : alt;
        valid = 1'($urandom);
        junk  = 7'($urandom);
        @(negedge clk);
      end
      valid = 1'b0;
    endtask

    // Stimulus
    initial begin
      int  starts;
      logic prev_busy;
      rst_n = 1'b0;
      valid = 1'b0;
      data  = 8'h00;
      junk  = 7'h00;
      repeat (2) @(negedge clk);
      check("reset_uo", 32'(uo), 32'h05);
      check("reset_uio", 32'({uio_o, uio_e}), 32'h0);
      rst_n = 1'b1;

      send(8'hA5, 1'b1, 8'h00);
      send(8'h07, 1'b1, 8'h00);
      send(8'h55, 1'b0, 8'hFF);
      send(8'h00, 1'b1, 8'h00);
      send(8'hFF, 1'b0, 8'h00);
      for (int i = 0; i < 12; i++) send(8'($urandom), 1'b1, 8'h00);

      // Back-to-back frames with tx_valid held high
      wait_idle();
      data  = 8'h3C;
      valid = 1'b1;
      q.push_back('{data: 8'h3C, b2b: 1'b0});
      q.push_back('{data: 8'h3C, b2b: 1'b1});
      q.push_back('{data: 8'h3C, b2b: 1'b1});
      starts    = 0;
      prev_busy = 1'b0;
      for (int t = 0; t < 4*NB*C && starts < 3; t++) begin
        @(negedge clk);
        if (uo[1] && !prev_busy) starts++;
        prev_busy = uo[1];
      end
      valid = 1'b0;
      check("b2b_starts", 32'(starts), 32'd3);

      // Asynchronous reset during data bit 3 aborts the frame
      wait_idle();
      mon_en = 1'b0;
      data   = 8'h55;
      valid  = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      repeat (4*C + 1) @(negedge clk);
      check("pre_reset_busy", 32'(uo[1]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_uo", 32'(uo), 32'h05);
      @(negedge clk);
      check("held_reset_uo", 32'(uo), 32'h05);
      rst_n  = 1'b1;
      data   = 8'h81;
      valid  = 1'b1;
      q.push_back('{data: 8'h81, b2b: 1'b0});
      mon_en = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      check("first_accept_after_reset", 32'(uo[1]), 32'd1);

      wait_idle();
      repeat (5) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      fin = 1'b1;
    end

    // Monitor: checks every sampled cycle against the popped expected frame
    initial begin
      int   gap;
      exp_t e;
      gap = 0;
      forever begin
        @(negedge clk);
        check("uio_zero", 32'({uio_o, uio_e}), 32'h0);
        if (rst_n && uo[1]) begin
          if (!mon_en || q.size() == 0) begin
            if (mon_en) check("unexpected_frame", 32'd1, 32'd0);
            while (uo[1]) @(negedge clk);
            gap = 0;
          end else begin
            e = q.pop_front();
            if (e.b2b) check("b2b_gap", 32'(gap), 32'd1);
            for (int k = 0; k < NB*C; k++) begin
              if (k > 0) @(negedge clk);
              check("tx_bit", 32'(uo[0]), 32'(exp_bit(e.data, k / C)));
              check("status_busy", 32'(uo[7:1]), 32'h01);
            end
            @(negedge clk);
            check("frame_end", 32'(uo), 32'h0D);
            gap = 1;
          end
        end else begin
          check("idle_status", 32'(uo), 32'h05);
          gap++;
        end
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(gen_u[0].fin && gen_u[1].fin) && t < 50000) begin
      @(negedge clk);
      t++;
    end
    if (!(gen_u[0].fin && gen_u[1].fin)) check("run_timeout", 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
